// File: rtl/gb_bus_responder.sv
// gb_bus_responder
// Responder end of the CPU core bus. Each CPU access is decoded and either
// served from internal storage (WRAM, HRAM, IE, IF, FF46 DMA register) or
// forwarded to the external (cartridge/VRAM), OAM or IO port. Also contains
// the OAM DMA engine, which copies DMA_LEN bytes from {FF46, 00} into OAM.
// While it runs, the CPU can only reach HRAM.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_rd_en/cpu_wr_en      CPU strobes; cpu_addr/cpu_wdata address and data
//   cpu_rdata                combinational read data (OPEN_BUS when not reading)
//   ext_*                    external port, 0000-BFFF (also the DMA source below C000)
//   oam_*                    OAM port, FE00-FE9F and the DMA destination
//   io_*                     IO port, FF00-FF7F except FF0F and FF46
//   irq_req                  interrupt request pulses, OR-ed into IF
//   if_out, ie_out           IF[4:0] and IE register contents
//   dma_active               DMA engine busy
module gb_bus_responder #(
    parameter int unsigned WRAM_AW  = 13,
    parameter int unsigned DMA_LEN  = 160,  // must be 1..256
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,

    output logic        ext_rd,
    output logic        ext_wr,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,

    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata,

    output logic        io_rd,
    output logic        io_wr,
    output logic [6:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,

    input  logic [4:0]  irq_req,
    output logic [4:0]  if_out,
    output logic [7:0]  ie_out,
    output logic        dma_active
);

    localparam int unsigned WramSize = 2 ** WRAM_AW;
    localparam logic [7:0]  LastIdx  = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StXfer
    } dma_state_e;

    typedef enum logic [3:0] {
        RgExt,
        RgWram,
        RgOam,
        RgUnused,
        RgIf,
        RgDma,
        RgIo,
        RgHram,
        RgIe
    } region_e;

    // State
    dma_state_e state_q, state_d;
    logic [7:0] dma_idx_q, dma_idx_d;
    logic [7:0] dma_src_q, dma_src_d;   // source page, echo already folded down
    logic [7:0] ff46_q, ff46_d;
    logic [7:0] ie_q, ie_d;
    logic [4:0] if_q, if_d;

    logic [7:0] wram_q [WramSize];
    logic [7:0] hram_q [127];

    // Decode / control
    region_e          region;
    logic             cpu_rd;
    logic             cpu_wr;
    logic             served;
    logic             if_wr;
    logic             dma_load;
    logic             wram_we;
    logic             hram_we;
    logic [7:0]       rd_mux;
    logic [7:0]       wram_cpu_rd;
    logic [7:0]       hram_cpu_rd;
    logic [15:0]      dma_src_addr;
    logic             dma_src_ext;
    logic [7:0]       dma_byte;

    assign dma_active = (state_q != StIdle);
    assign if_out     = if_q;
    assign ie_out     = ie_q;

    // A simultaneous read and write is treated as a write only.
    assign cpu_wr = cpu_wr_en;
    assign cpu_rd = cpu_rd_en & ~cpu_wr_en;

    assign wram_cpu_rd = wram_q[cpu_addr[WRAM_AW-1:0]];
    assign hram_cpu_rd = hram_q[cpu_addr[6:0]];

    assign dma_src_addr = {dma_src_q, dma_idx_q};
    assign dma_src_ext  = (dma_src_addr < 16'hC000);
    assign dma_byte     = dma_src_ext ? ext_rdata : wram_q[dma_src_addr[WRAM_AW-1:0]];

    // Address region decode.
    always_comb begin
        if (cpu_addr < 16'hC000) begin
            region = RgExt;
        end else if (cpu_addr < 16'hFE00) begin
            region = RgWram;
        end else if (cpu_addr < 16'hFEA0) begin
            region = RgOam;
        end else if (cpu_addr < 16'hFF00) begin
            region = RgUnused;
        end else if (cpu_addr == 16'hFF0F) begin
            region = RgIf;
        end else if (cpu_addr == 16'hFF46) begin
            region = RgDma;
        end else if (cpu_addr < 16'hFF80) begin
            region = RgIo;
        end else if (cpu_addr == 16'hFFFF) begin
            region = RgIe;
        end else begin
            region = RgHram;
        end
    end

    // CPU access routing, then DMA overlay on the ext/OAM ports.
    always_comb begin
        ext_rd    = 1'b0;
        ext_wr    = 1'b0;
        ext_addr  = 16'h0000;
        ext_wdata = 8'h00;
        oam_we    = 1'b0;
        oam_addr  = 8'h00;
        oam_wdata = 8'h00;
        io_rd     = 1'b0;
        io_wr     = 1'b0;
        io_addr   = 7'h00;
        io_wdata  = 8'h00;
        if_wr     = 1'b0;
        dma_load  = 1'b0;
        wram_we   = 1'b0;
        hram_we   = 1'b0;
        ie_d      = ie_q;
        ff46_d    = ff46_q;
        rd_mux    = OPEN_BUS;

        // During DMA only HRAM is reachable; everything else is open bus / dropped.
        served = (cpu_rd | cpu_wr) & (~dma_active | (region == RgHram));

        if (served) begin
            case (region)
                RgExt: begin
                    ext_rd    = cpu_rd;
                    ext_wr    = cpu_wr;
                    ext_addr  = cpu_addr;
                    ext_wdata = cpu_wr ? cpu_wdata : 8'h00;
                    rd_mux    = ext_rdata;
                end
                RgWram: begin
                    wram_we = cpu_wr;
                    rd_mux  = wram_cpu_rd;
                end
                RgOam: begin
                    oam_we    = cpu_wr;
                    oam_addr  = cpu_addr[7:0];
                    oam_wdata = cpu_wr ? cpu_wdata : 8'h00;
                    rd_mux    = oam_rdata;
                end
                RgIf: begin
                    if_wr  = cpu_wr;
                    rd_mux = {3'b111, if_q};
                end
                RgDma: begin
                    rd_mux = ff46_q;
                    if (cpu_wr) begin
                        ff46_d   = cpu_wdata;
                        dma_load = 1'b1;
                    end
                end
                RgIo: begin
                    io_rd    = cpu_rd;
                    io_wr    = cpu_wr;
                    io_addr  = cpu_addr[6:0];
                    io_wdata = cpu_wr ? cpu_wdata : 8'h00;
                    rd_mux   = io_rdata;
                end
                RgHram: begin
                    hram_we = cpu_wr;
                    rd_mux  = hram_cpu_rd;
                end
                RgIe: begin
                    if (cpu_wr) begin
                        ie_d = cpu_wdata;
                    end
                    rd_mux = ie_q;
                end
                default: begin
                    // FEA0-FEFF: reads open bus, writes dropped.
                    rd_mux = OPEN_BUS;
                end
            endcase
        end

        cpu_rdata = (served & cpu_rd) ? rd_mux : OPEN_BUS;

        // The CPU cannot reach ext/OAM while DMA is active, so no conflict here.
        if (state_q == StXfer) begin
            ext_rd    = dma_src_ext;
            ext_addr  = dma_src_ext ? dma_src_addr : 16'h0000;
            oam_we    = 1'b1;
            oam_addr  = dma_idx_q;
            oam_wdata = dma_byte;
        end
    end

    // IF: CPU write replaces the bits, requests always OR in on top.
    always_comb begin
        if_d = (if_wr ? cpu_wdata[4:0] : if_q) | irq_req;
    end

    // DMA FSM next state.
    always_comb begin
        state_d   = state_q;
        dma_idx_d = dma_idx_q;
        dma_src_d = dma_src_q;

        unique case (state_q)
            StIdle: begin
                if (dma_load) begin
                    state_d   = StStart;
                    dma_idx_d = 8'h00;
                    // E0-FF pages echo WRAM at C0-DF.
                    dma_src_d = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
                end
            end
            StStart: begin
                state_d = StXfer;
            end
            StXfer: begin
                dma_idx_d = dma_idx_q + 8'h01;
                if (dma_idx_q == LastIdx) begin
                    state_d   = StIdle;
                    dma_idx_d = 8'h00;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            dma_idx_q <= 8'h00;
            dma_src_q <= 8'h00;
            ff46_q    <= 8'hFF;
            ie_q      <= 8'h00;
            if_q      <= 5'h00;
        end else begin
            state_q   <= state_d;
            dma_idx_q <= dma_idx_d;
            dma_src_q <= dma_src_d;
            ff46_q    <= ff46_d;
            ie_q      <= ie_d;
            if_q      <= if_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wram_we) begin
            wram_q[cpu_addr[WRAM_AW-1:0]] <= cpu_wdata;
        end
        if (hram_we) begin
            hram_q[cpu_addr[6:0]] <= cpu_wdata;
        end
    end

endmodule

// File: doc/gb_bus_responder.md
Name: gb_bus_responder

Overview:
Responder end of the CPU core's bus (rd_en/wr_en/addr/data). It decodes each CPU access and serves it from internal WRAM, HRAM and the IE/IF registers, or forwards it to an external port (cartridge/VRAM), the OAM port or the IO port. It also contains the OAM DMA engine triggered by writes to FF46, and blocks the CPU from non-HRAM space while DMA runs.

Parameters:
WRAM_AW, 13, WRAM address width (8 KiB at C000-DFFF, echoed at E000-FDFF)
DMA_LEN, 160, bytes copied per OAM DMA
OPEN_BUS, 8'hFF, value returned for unmapped or blocked reads

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpu_rd_en  in  1  CPU read strobe
cpu_wr_en  in  1  CPU write strobe
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  read data, combinational, valid in the same cycle as cpu_rd_en
ext_rd  out  1  external read strobe (0000-BFFF)
ext_wr  out  1  external write strobe
ext_addr  out  16  external address
ext_wdata  out  8  external write data
ext_rdata  in  8  external read data, combinational
oam_we  out  1  OAM write strobe
oam_addr  out  8  OAM byte index
oam_wdata  out  8  OAM write data
oam_rdata  in  8  OAM read data, combinational
io_rd  out  1  IO read strobe (FF00-FF7F, except FF0F and FF46)
io_wr  out  1  IO write strobe
io_addr  out  7  IO offset
io_wdata  out  8  IO write data
io_rdata  in  8  IO read data
irq_req  in  5  interrupt request pulses, OR-ed into IF
if_out  out  5  IF[4:0]
ie_out  out  8  IE register
dma_active  out  1  DMA engine busy

Behaviour:
- Decode. All strobes are combinational from the CPU strobes and address. Internal writes commit at posedge.
  - 0000-BFFF: ext.
  - C000-FDFF: WRAM, index addr[WRAM_AW-1:0].
  - FE00-FE9F: OAM; reads go to oam_rdata.
  - FEA0-FEFF: reads OPEN_BUS; writes dropped.
  - FF0F: IF.
  - FF46: DMA register.
  - Other FF00-FF7F: IO.
  - FF80-FFFE: HRAM (127 B).
  - FFFF: IE.
- cpu_rdata is OPEN_BUS when cpu_rd_en=0. If cpu_rd_en and cpu_wr_en are both set, the write wins and cpu_rdata is OPEN_BUS.
- IF reads {3'b111, IF[4:0]}.
  - IF next value = (CPU write to FF0F ? wdata[4:0] : IF) | irq_req.
  - A request in the same cycle as a CPU write is never lost.
- IE is a full 8-bit read/write register.
- FF46 reads the last value written.
- Reset values:
  - IE=00, IF=00, FF46 reg=FF, DMA state IDLE.
  - All strobes 0; dma_active=0; ext_addr, oam_addr, io_addr and all write-data outputs 0 when idle.
  - WRAM and HRAM contents are not reset.
- DMA FSM (states IDLE, START, XFER). Let the FF46 write land at posedge N.
  - IDLE: a write to FF46 loads src_hi and goes to START.
  - START: lasts one cycle (cycle N+1); dma_active=1.
  - XFER: byte i (0..DMA_LEN-1) moves in cycle N+2+i.
    - Source address = {src_hi', i}, where src_hi' = src_hi-0x20 when src_hi>=E0, else src_hi.
    - Source < C000: drive ext_rd=1, ext_addr=source, data=ext_rdata. Otherwise read WRAM.
    - In the same cycle: oam_we=1, oam_addr=i, oam_wdata=source byte.
  - After i=DMA_LEN-1, return to IDLE at cycle N+2+DMA_LEN. dma_active=1 for cycles N+1..N+1+DMA_LEN.
- CPU access while dma_active=1:
  - Only FF80-FFFE is served.
  - All other reads return OPEN_BUS; all other writes (including FF46, IE, IF) are dropped.
  - The CPU never drives ext or oam strobes.
  - irq_req still sets IF.
- Reset during DMA: abort immediately, IDLE next cycle, no further oam_we, OAM contents as already written.

Test Plan:
- Write 5A to FF80, read FF80 -> 5A. Write 77 to FFFF -> ie_out=77, read FFFF -> 77.
- Write 3C to C123, read E123 -> 3C. Read FEA5 -> FF.
- Set IF=01, then in one cycle write 04 to FF0F with irq_req=02 -> if_out=06, read FF0F -> E6.
- Fill C100-C19F with i^A5, write C1 to FF46:
  - dma_active=1 for exactly 161 cycles.
  - oam_we for 160 consecutive cycles starting 2 cycles after the write, oam_wdata=i^A5 at oam_addr=i.
  - During DMA: read C100 -> FF, HRAM read/write works, write to FFFF dropped.
- Write 20 to FF46 -> ext_rd/ext_addr step 2000..209F and ext_rdata is copied to OAM. Write E1 to FF46 -> source C100-C19F.
- Assert rst at XFER i=50 -> no oam_we after reset, dma_active=0, FF46 reads FF, IE=00, IF reads E0.
